// File: rtl/fetch_stage.sv
`timescale 1ns/1ps
// fetch_stage: instruction fetch FSM feeding a 2-entry {pc+4, instruction} queue into IF/ID.
// Latency: a zero-wait imem ack shows the instruction on inst_out the next cycle (no bypass).
// Backpressure: id_ready=0 holds the queue head; no request is issued that could overflow it.
// Optional feature: define FETCH_PERF_CNT_EN to add the fetch_stall_cnt output.
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    input  logic        id_ready,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    output logic        inst_valid,
    output logic [31:0] inst_out,
    output logic [31:0] adrIF
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0] fetch_stall_cnt
`endif
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_REQ    = 2'd1,
        ST_SQUASH = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [31:0]     fetch_pc_q, fetch_pc_d;
    logic [31:0]     addr_q, addr_d;
    logic            req_q, req_d;
    logic [1:0]      occ_q, occ_d;
    logic            head_q, head_d;
    logic [1:0][31:0] q_pc4_q, q_pc4_d;
    logic [1:0][31:0] q_inst_q, q_inst_d;

    logic            ack_vld;
    logic            pop;
    logic            push;
    logic [1:0]      occ_pop;
    logic [1:0]      occ_next;
    logic            tail_idx;
    logic [31:0]     pc_inc;

    assign imem_req   = req_q;
    assign imem_addr  = addr_q;
    assign inst_valid = (occ_q != 2'd0);
    assign inst_out   = q_inst_q[head_q];
    assign adrIF      = q_pc4_q[head_q];

    // An ack only counts while a request is actually outstanding.
    assign ack_vld  = req_q & imem_ack;
    assign pop      = inst_valid & id_ready;
    assign pc_inc   = fetch_pc_q + 32'd4;
    assign occ_pop  = occ_q - {1'b0, pop};
    // Tail slot is head+occupancy mod 2; a push never happens with two entries held.
    assign tail_idx = head_q ^ occ_q[0];

    // Next-state logic: a redirect flushes the queue and overrides any push/pop this cycle.
    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        addr_d     = addr_q;
        req_d      = req_q;
        occ_d      = occ_q;
        head_d     = head_q;
        q_pc4_d    = q_pc4_q;
        q_inst_d   = q_inst_q;
        push       = 1'b0;
        occ_next   = occ_pop;
        if (branch_taken) begin
            occ_d      = 2'd0;
            fetch_pc_d = branch_target;
            if (state_q != ST_IDLE && !ack_vld) begin
                // Bus request cannot be withdrawn: keep the stale address and drop its data later.
                state_d = ST_SQUASH;
            end else begin
                state_d = ST_REQ;
                addr_d  = branch_target;
                req_d   = 1'b1;
            end
        end else begin
            push     = (state_q == ST_REQ) && ack_vld;
            occ_next = occ_pop + {1'b0, push};
            occ_d    = occ_next;
            if (pop) begin
                head_d = ~head_q;
            end
            if (push) begin
                q_pc4_d[tail_idx]  = pc_inc;
                q_inst_d[tail_idx] = imem_rdata;
            end
            case (state_q)
                ST_IDLE: begin
                    if (occ_pop != 2'd2) begin
                        state_d = ST_REQ;
                        addr_d  = fetch_pc_q;
                        req_d   = 1'b1;
                    end
                end
                ST_REQ: begin
                    if (ack_vld) begin
                        fetch_pc_d = pc_inc;
                        addr_d     = pc_inc;
                        if (occ_next == 2'd2) begin
                            state_d = ST_IDLE;
                            req_d   = 1'b0;
                        end
                    end
                end
                ST_SQUASH: begin
                    if (ack_vld) begin
                        state_d = ST_REQ;
                        addr_d  = fetch_pc_q;
                        req_d   = 1'b1;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    addr_d  = fetch_pc_q;
                    req_d   = 1'b0;
                end
            endcase
        end
    end

    // FSM, fetch pointer, registered bus outputs and queue storage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            fetch_pc_q <= RESET_PC;
            addr_q     <= RESET_PC;
            req_q      <= 1'b0;
            occ_q      <= 2'd0;
            head_q     <= 1'b0;
            q_pc4_q    <= '0;
            q_inst_q   <= '0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            addr_q     <= addr_d;
            req_q      <= req_d;
            occ_q      <= occ_d;
            head_q     <= head_d;
            q_pc4_q    <= q_pc4_d;
            q_inst_q   <= q_inst_d;
        end
    end

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;

    // Count cycles where decode could accept but fetch has nothing to give.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (id_ready && !inst_valid && !branch_taken) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
    end

    // Stall counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q <= 32'd0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign fetch_stall_cnt = stall_cnt_q;
`endif

endmodule
